// File: rtl/tx_tune_controller.sv
// Channel-change sequencer for the FM transmit chain: mutes audio with a gain ramp,
// retunes the DUC phase increment, waits for the pipeline to flush, then ramps audio back up.
module tx_tune_controller #(
    parameter int FCLK          = 200000000,
    parameter int PHASE_WIDTH   = 32,
    parameter int BASE_FREQ     = 88000000,
    parameter int STEP_FREQ     = 200000,
    parameter int NUM_CH        = 100,
    parameter int CH_BITS       = 7,
    parameter int DEFAULT_CH    = 55,
    parameter int RAMP_STEP     = 1,
    parameter int FLUSH_SAMPLES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CH_BITS-1:0]     req_ch,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [15:0]            audio_in,
    input  logic                   audio_stb_in,
    output logic [15:0]            audio_out,
    output logic                   audio_stb_out,
    output logic [PHASE_WIDTH-1:0] fcw_out,
    output logic                   fcw_load,
    output logic [CH_BITS-1:0]     cur_ch,
    output logic                   busy,
    output logic                   err,
    output logic [2:0]             state_dbg,
    output logic [8:0]             gain_dbg
);

    localparam logic [PHASE_WIDTH-1:0] BASE_WORD =
        PHASE_WIDTH'((64'(BASE_FREQ) << PHASE_WIDTH) / 64'(FCLK));
    localparam logic [PHASE_WIDTH-1:0] STEP_WORD =
        PHASE_WIDTH'((64'(STEP_FREQ) << PHASE_WIDTH) / 64'(FCLK));
    localparam int CNT_W = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
    localparam int FL_W  = $clog2(FLUSH_SAMPLES + 1);
    localparam logic [8:0] GAIN_FULL = 9'd256;
    localparam logic [8:0] GAIN_STEP = 9'(RAMP_STEP);
    localparam logic [CH_BITS-1:0] BOOT_CH = CH_BITS'(DEFAULT_CH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RAMP_DN = 3'd1,
        S_CALC    = 3'd2,
        S_LOAD    = 3'd3,
        S_FLUSH   = 3'd4,
        S_RAMP_UP = 3'd5
    } state_t;

    // Handshake: a request transfers on a clock edge where req_valid && req_ready;
    // req_ready is registered and only high in IDLE, so the requester holds valid until then.

    state_t                 state_q;
    logic [8:0]             gain_q;
    logic [CH_BITS-1:0]     target_q;
    logic [CH_BITS-1:0]     cur_ch_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [PHASE_WIDTH-1:0] prod_q;
    logic [FL_W-1:0]        flush_cnt_q;
    logic [PHASE_WIDTH-1:0] fcw_q;
    logic                   fcw_load_q;
    logic [15:0]            audio_out_q;
    logic                   audio_stb_q;
    logic                   req_ready_q;
    logic                   busy_q;
    logic                   err_q;
    logic signed [24:0]     audio_prod;

    // Gain is unsigned 0..256, so a zero-extended sign bit keeps the product signed.
    assign audio_prod = 25'($signed(audio_in) * $signed({1'b0, gain_q}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_CALC;
            gain_q      <= '0;
            target_q    <= BOOT_CH;
            cur_ch_q    <= BOOT_CH;
            bit_cnt_q   <= '0;
            prod_q      <= '0;
            flush_cnt_q <= '0;
            fcw_q       <= '0;
            fcw_load_q  <= 1'b0;
            audio_out_q <= '0;
            audio_stb_q <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            fcw_load_q  <= 1'b0;
            err_q       <= 1'b0;
            audio_stb_q <= audio_stb_in;
            if (audio_stb_in) begin
                audio_out_q <= 16'(audio_prod >>> 8);
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        if (32'(req_ch) >= NUM_CH) begin
                            err_q <= 1'b1;
                        end else if (req_ch != cur_ch_q) begin
                            target_q    <= req_ch;
                            state_q     <= S_RAMP_DN;
                            req_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                S_RAMP_DN: begin
                    if (audio_stb_in) begin
                        if (gain_q > GAIN_STEP) begin
                            gain_q <= gain_q - GAIN_STEP;
                        end else begin
                            gain_q    <= '0;
                            bit_cnt_q <= '0;
                            prod_q    <= '0;
                            state_q   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // One multiplier bit per clock: prod += target[i] * (STEP_WORD << i).
                    if (target_q[bit_cnt_q]) begin
                        prod_q <= prod_q + (STEP_WORD << bit_cnt_q);
                    end
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_W'(CH_BITS - 1)) begin
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    fcw_q       <= BASE_WORD + prod_q;
                    fcw_load_q  <= 1'b1;
                    cur_ch_q    <= target_q;
                    flush_cnt_q <= '0;
                    state_q     <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (audio_stb_in) begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                        if (flush_cnt_q == FL_W'(FLUSH_SAMPLES - 1)) begin
                            state_q <= S_RAMP_UP;
                        end
                    end
                end
                S_RAMP_UP: begin
                    if (audio_stb_in) begin
                        if (gain_q >= GAIN_FULL - GAIN_STEP) begin
                            gain_q      <= GAIN_FULL;
                            state_q     <= S_IDLE;
                            req_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            gain_q <= gain_q + GAIN_STEP;
                        end
                    end
                end
                default: begin
                    state_q <= S_CALC;
                end
            endcase
        end
    end

    assign req_ready     = req_ready_q;
    assign audio_out     = audio_out_q;
    assign audio_stb_out = audio_stb_q;
    assign fcw_out       = fcw_q;
    assign fcw_load      = fcw_load_q;
    assign cur_ch        = cur_ch_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign state_dbg     = state_q;
    assign gain_dbg      = gain_q;

endmodule
